// File: rtl/hilo_muldiv_sequencer_if.sv
// hilo_muldiv_sequencer_if: op handshake and Hi/Lo result bundle for the muldiv sequencer
interface hilo_muldiv_sequencer_if;
  logic        OpValid;
  logic        OpReady;
  logic [5:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic [31:0] Result;
  logic        ResultValid;
  logic        Busy;
  logic        Done;
  modport master (output OpValid, ALUControl, A, B, input OpReady, Hi, Lo, Result, ResultValid, Busy, Done);
  modport slave (input OpValid, ALUControl, A, B, output OpReady, Hi, Lo, Result, ResultValid, Busy, Done);
endinterface

// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer: iterative shift-add Hi/Lo multiply/accumulate unit with mthi/mtlo/mfhi/mflo
module hilo_muldiv_sequencer #(
  parameter int STEP_BITS = 1
) (
  input logic Clk,
  input logic Rst,
  hilo_muldiv_sequencer_if.slave bus
);
  localparam int ITER = 32 / STEP_BITS;
  localparam logic [5:0] MULT = 6'b000110, MULTU = 6'b000111, MADD = 6'b001000, MSUB = 6'b001001;
  localparam logic [5:0] MTHI = 6'b010000, MTLO = 6'b010001, MFHI = 6'b010010, MFLO = 6'b010011;
  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
  state_t state, state_nx;
  logic [5:0] op, cnt;
  logic [63:0] mcand, prod, pp, p, hilo, commit;
  logic [32:0] mplier, a_ext, b_ext, a_mag, b_mag;
  logic [31:0] hi, lo, result;
  logic neg, sgn, accept, is_mul, rv, done;
  // accept decode and 33-bit operand magnitudes so 0x80000000 survives negation
  always_comb begin
    accept = bus.OpValid && state == IDLE;
    is_mul = bus.ALUControl inside {MULT, MULTU, MADD, MSUB};
    sgn = bus.ALUControl != MULTU;
    a_ext = {sgn & bus.A[31], bus.A};
    b_ext = {sgn & bus.B[31], bus.B};
    a_mag = a_ext[32] ? -a_ext : a_ext;
    b_mag = b_ext[32] ? -b_ext : b_ext;
  end
  // partial-product digit, sign fix-up and Hi/Lo commit value
  always_comb begin
    pp = '0;
    for (int i = 0; i < STEP_BITS; i++)
      if (mplier[i]) pp = pp + (mcand << i);
    p = neg ? -prod : prod;
    hilo = {hi, lo};
    commit = (op == MADD) ? hilo + p : (op == MSUB) ? hilo - p : p;
  end
  // next-state: a multiply walks IDLE -> MUL (ITER edges) -> FIX -> IDLE
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = (accept && is_mul) ? MUL : IDLE;
    else if (state == MUL) state_nx = (cnt == 6'(ITER - 1)) ? FIX : MUL;
    else state_nx = IDLE;
  end
  // state register; reset aborts any in-flight multiply
  always_ff @(posedge Clk) state <= Rst ? IDLE : state_nx;
  // datapath: operand latch, shift-add iterations, commit and register moves
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi <= '0;
      lo <= '0;
      result <= '0;
      rv <= 1'b0;
      done <= 1'b0;
      op <= '0;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      prod <= '0;
      neg <= 1'b0;
    end else begin
      rv <= accept && (bus.ALUControl == MFHI || bus.ALUControl == MFLO);
      done <= state == FIX;
      if (accept) begin
        op <= bus.ALUControl;
        cnt <= '0;
        mcand <= {31'b0, a_mag};
        mplier <= b_mag;
        prod <= '0;
        neg <= sgn & (bus.A[31] ^ bus.B[31]);
        if (bus.ALUControl == MTHI) hi <= bus.A;
        if (bus.ALUControl == MTLO) lo <= bus.A;
        if (bus.ALUControl == MFHI) result <= hi;
        if (bus.ALUControl == MFLO) result <= lo;
      end
      if (state == MUL) begin
        prod <= prod + pp;
        mcand <= mcand << STEP_BITS;
        mplier <= mplier >> STEP_BITS;
        cnt <= cnt + 6'd1;
      end
      if (state == FIX) {hi, lo} <= commit;
    end
  end
  assign bus.OpReady = state == IDLE;
  assign bus.Busy = state != IDLE;
  assign bus.Hi = hi;
  assign bus.Lo = lo;
  assign bus.Result = result;
  assign bus.ResultValid = rv;
  assign bus.Done = done;
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb_hilo_muldiv_sequencer: vector table plus scoreboard checks of the Hi/Lo muldiv sequencer
module tb_hilo_muldiv_sequencer;
  localparam logic [5:0] MULT = 6'b000110, MULTU = 6'b000111, MADD = 6'b001000, MSUB = 6'b001001;
  localparam logic [5:0] MTHI = 6'b010000, MTLO = 6'b010001, MFHI = 6'b010010, MFLO = 6'b010011;
  typedef struct {
    logic v;
    logic [5:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  logic Clk, Rst, op_valid;
  logic [5:0] alu;
  logic [31:0] opa, opb;
  int applied = 0, errs = 0;
  logic [63:0] hl_q[$];
  logic [31:0] res_q[$];
  vec_t tbl[20];
  hilo_muldiv_sequencer_if bus1 ();
  hilo_muldiv_sequencer_if bus2 ();
  hilo_muldiv_sequencer_if bus4 ();
  assign bus1.OpValid = op_valid;
  assign bus1.ALUControl = alu;
  assign bus1.A = opa;
  assign bus1.B = opb;
  assign bus2.OpValid = op_valid;
  assign bus2.ALUControl = alu;
  assign bus2.A = opa;
  assign bus2.B = opb;
  assign bus4.OpValid = op_valid;
  assign bus4.ALUControl = alu;
  assign bus4.A = opa;
  assign bus4.B = opb;
  hilo_muldiv_sequencer #(.STEP_BITS(1)) dut1 (.Clk(Clk), .Rst(Rst), .bus(bus1));
  hilo_muldiv_sequencer #(.STEP_BITS(2)) dut2 (.Clk(Clk), .Rst(Rst), .bus(bus2));
  hilo_muldiv_sequencer #(.STEP_BITS(4)) dut4 (.Clk(Clk), .Rst(Rst), .bus(bus4));
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  function automatic logic is_mul(input logic [5:0] op);
    return op inside {MULT, MULTU, MADD, MSUB};
  endfunction
  function automatic logic is_mf(input logic [5:0] op);
    return op == MFHI || op == MFLO;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // scoreboard: every Done / ResultValid pulse must match the oldest pending expectation
  always @(negedge Clk) begin
    if (!Rst) begin
      if (bus1.Done) begin
        if (hl_q.size() != 0) chk("done_hilo", {bus1.Hi, bus1.Lo}, hl_q.pop_front());
        else chk("unexpected_done", 64'(bus1.Done), 64'd0);
      end
      if (bus1.ResultValid) begin
        if (res_q.size() != 0) chk("result", 64'(bus1.Result), 64'(res_q.pop_front()));
        else chk("unexpected_result_valid", 64'(bus1.ResultValid), 64'd0);
      end
    end
  end
  task automatic wait_ready(input string name, output int w);
    w = 0;
    while (!bus1.OpReady && w < 100) begin
      @(negedge Clk);
      w++;
    end
    if (w >= 100) chk({name, "_ready_timeout"}, 64'(w), 64'd0);
  endtask
  task automatic issue(input vec_t t);
    int w;
    @(negedge Clk);
    op_valid = t.v;
    alu = t.op;
    opa = t.a;
    opb = t.b;
    wait_ready("issue", w);
    if (t.v && is_mul(t.op)) hl_q.push_back(t.exp);
    else if (t.v && is_mf(t.op)) res_q.push_back(t.exp[31:0]);
    @(posedge Clk);
    #1;
    op_valid = 1'b0;
    if (t.v && is_mul(t.op)) chk($sformatf("busy_after_%h", t.op), 64'(bus1.Busy), 64'd1);
    else if (!(t.v && is_mf(t.op))) chk($sformatf("hilo_after_%h", t.op), {bus1.Hi, bus1.Lo}, t.exp);
  endtask
  task automatic drain();
    int w;
    w = 0;
    while ((hl_q.size() != 0 || res_q.size() != 0 || !bus1.OpReady) && w < 200) begin
      @(negedge Clk);
      w++;
    end
    chk("pending_expectations", 64'(hl_q.size() + res_q.size()), 64'd0);
  endtask
  task automatic reset_all();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask
  initial begin
    int w, dn, l1, l2, l4;
    logic [63:0] h2, h4;
    op_valid = 1'b0;
    alu = '0;
    opa = '0;
    opb = '0;
    tbl[0]  = '{1'b1, MULT,  32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
    tbl[1]  = '{1'b1, MFHI,  32'd0,        32'd0,        64'h00000000_FFFFFFFF};
    tbl[2]  = '{1'b1, MFLO,  32'd0,        32'd0,        64'h00000000_FFFFFFF1};
    tbl[3]  = '{1'b1, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    tbl[4]  = '{1'b1, MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000};
    tbl[5]  = '{1'b1, MULT,  32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
    tbl[6]  = '{1'b1, MTHI,  32'd0,        32'd0,        64'h00000000_80000000};
    tbl[7]  = '{1'b1, MTLO,  32'h10,       32'd0,        64'h00000000_00000010};
    tbl[8]  = '{1'b1, MADD,  32'd2,        32'd3,        64'h00000000_00000016};
    tbl[9]  = '{1'b0, MTHI,  32'hDEADBEEF, 32'd0,        64'h00000000_00000016};
    tbl[10] = '{1'b1, 6'h3F, 32'hDEADBEEF, 32'd7,        64'h00000000_00000016};
    tbl[11] = '{1'b1, MTLO,  32'd0,        32'd0,        64'h00000000_00000000};
    tbl[12] = '{1'b1, MSUB,  32'd1,        32'd1,        64'hFFFFFFFF_FFFFFFFF};
    tbl[13] = '{1'b1, MADD,  32'hFFFFFFFF, 32'd1,        64'hFFFFFFFF_FFFFFFFE};
    tbl[14] = '{1'b1, MSUB,  32'h80000000, 32'hFFFFFFFF, 64'hFFFFFFFF_7FFFFFFE};
    tbl[15] = '{1'b1, MULTU, 32'h80000000, 32'd2,        64'h00000001_00000000};
    tbl[16] = '{1'b1, MTHI,  32'h12345678, 32'd0,        64'h12345678_00000000};
    tbl[17] = '{1'b1, MFHI,  32'd0,        32'd0,        64'h00000000_12345678};
    tbl[18] = '{1'b1, MULT,  32'd7,        32'd9,        64'h00000000_0000003F};
    tbl[19] = '{1'b1, MFLO,  32'd0,        32'd0,        64'h00000000_0000003F};
    reset_all();
    chk("reset_hilo", {bus1.Hi, bus1.Lo}, 64'd0);
    chk("reset_result", 64'(bus1.Result), 64'd0);
    chk("reset_flags", {61'd0, bus1.OpReady, bus1.Busy, bus1.Done | bus1.ResultValid}, 64'd4);
    for (int i = 0; i < 20; i++) issue(tbl[i]);
    drain();
    issue('{1'b1, MULT, 32'd7, 32'd9, 64'h3F});
    @(negedge Clk);
    op_valid = 1'b1;
    alu = MFLO;
    res_q.push_back(32'h3F);
    wait_ready("mflo_hazard", w);
    chk("mflo_stall_cycles", 64'(w), 64'd33);
    chk("mflo_accept_in_done", 64'(bus1.Done), 64'd1);
    @(posedge Clk);
    #1;
    op_valid = 1'b0;
    chk("mflo_result_valid", 64'(bus1.ResultValid), 64'd1);
    chk("mflo_result", 64'(bus1.Result), 64'h3F);
    @(posedge Clk);
    #1;
    chk("result_valid_pulse", 64'(bus1.ResultValid), 64'd0);
    drain();
    issue('{1'b1, MULT, 32'd7, 32'd9, 64'h3F});
    @(negedge Clk);
    op_valid = 1'b1;
    alu = MADD;
    opa = 32'd2;
    opb = 32'd3;
    hl_q.push_back(64'h45);
    wait_ready("madd_b2b", w);
    chk("madd_accept_in_done", 64'(bus1.Done), 64'd1);
    @(posedge Clk);
    #1;
    op_valid = 1'b0;
    opa = 32'hFFFF0000;
    opb = 32'h0000FFFF;
    chk("madd_b2b_busy", 64'(bus1.OpReady), 64'd0);
    drain();
    issue('{1'b1, MTHI, 32'h1234, 32'd0, 64'h00001234_00000045});
    issue('{1'b1, MTLO, 32'h1234, 32'd0, 64'h00001234_00001234});
    @(negedge Clk);
    op_valid = 1'b1;
    alu = MULT;
    opa = 32'd3;
    opb = 32'd3;
    @(posedge Clk);
    #1;
    op_valid = 1'b0;
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk("abort_hilo", {bus1.Hi, bus1.Lo}, 64'd0);
    chk("abort_ready", 64'(bus1.OpReady), 64'd1);
    chk("abort_busy", 64'(bus1.Busy), 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge Clk);
      if (bus1.Done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    reset_all();
    @(negedge Clk);
    op_valid = 1'b1;
    alu = MULT;
    opa = 32'hFFFFFFFD;
    opb = 32'd5;
    hl_q.push_back(64'hFFFFFFFF_FFFFFFF1);
    @(posedge Clk);
    #1;
    op_valid = 1'b0;
    l1 = 0;
    l2 = 0;
    l4 = 0;
    h2 = '0;
    h4 = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge Clk);
      #1;
      if (bus1.Done && l1 == 0) l1 = n;
      if (bus2.Done && l2 == 0) begin
        l2 = n;
        h2 = {bus2.Hi, bus2.Lo};
      end
      if (bus4.Done && l4 == 0) begin
        l4 = n;
        h4 = {bus4.Hi, bus4.Lo};
      end
    end
    chk("latency_step1", 64'(l1), 64'd33);
    chk("latency_step2", 64'(l2), 64'd17);
    chk("latency_step4", 64'(l4), 64'd9);
    chk("hilo_step2", h2, 64'hFFFFFFFF_FFFFFFF1);
    chk("hilo_step4", h4, 64'hFFFFFFFF_FFFFFFF1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end
endmodule
